// File: rtl/send_queue_if.sv
// Payload type and handshake interface shared by the send queue, the decode/issue stage and the postoffice.
package send_queue_pkg;

    typedef struct packed {
        logic [4:0]  register;
        logic [31:0] message;
    } send_queue_data_t;

endpackage

interface send_queue_if
    import send_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
);

    logic             decode_send_queue_valid;
    logic             send_queue_decode_ready;
    send_queue_data_t decode_send_queue_data;
    logic             send_queue_postoffice_valid;
    logic             postoffice_send_queue_ready;
    send_queue_data_t send_queue_postoffice_data;
    logic [CNT_W-1:0] send_queue_count;
    logic             send_queue_empty;

    // The queue itself is the slave; decode/postoffice (or a bench) take the master side.
    modport slave (
        input  decode_send_queue_valid,
        input  decode_send_queue_data,
        input  postoffice_send_queue_ready,
        output send_queue_decode_ready,
        output send_queue_postoffice_valid,
        output send_queue_postoffice_data,
        output send_queue_count,
        output send_queue_empty
    );

    modport master (
        output decode_send_queue_valid,
        output decode_send_queue_data,
        output postoffice_send_queue_ready,
        input  send_queue_decode_ready,
        input  send_queue_postoffice_valid,
        input  send_queue_postoffice_data,
        input  send_queue_count,
        input  send_queue_empty
    );

endinterface

// File: rtl/send_queue.sv
// In-order circular-buffer FIFO of resolved send requests waiting for the postoffice.
module send_queue
    import send_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    send_queue_if.slave sq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    send_queue_data_t mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Ready comes only from registered occupancy, so a full queue refuses a push even while popping.
    assign push = sq.decode_send_queue_valid & ~full & ~flush;
    assign pop  = ~empty & sq.postoffice_send_queue_ready & ~flush;

    assign sq.send_queue_decode_ready     = ~full;
    assign sq.send_queue_postoffice_valid = ~empty;
    assign sq.send_queue_postoffice_data  = mem_q[head_q];
    assign sq.send_queue_count            = count_q;
    assign sq.send_queue_empty            = empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
        end
        if (push) begin
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= sq.decode_send_queue_data;
        end
    end

endmodule

// File: tb/tb_send_queue.sv
// Scoreboard bench for send_queue: accepted requests are queued and compared against the head every cycle.
module tb_send_queue;
    import send_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   errors;

    send_queue_data_t sb[$];

    send_queue_if #(.DEPTH(DEPTH)) sqi ();

    send_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .sq    (sqi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, checks outputs mid-cycle against the model, then updates the model.
    task automatic applyStimulus(input logic valid, input logic [4:0] reg_id, input logic [31:0] msg,
                                 input logic po_ready, input logic fl);
        send_queue_data_t req;
        int model_count;
        req.register = reg_id;
        req.message  = msg;
        sqi.decode_send_queue_valid     = valid;
        sqi.decode_send_queue_data      = req;
        sqi.postoffice_send_queue_ready = po_ready;
        flush                           = fl;
        @(negedge clk);
        model_count = sb.size();
        checkOutput("count", 64'(sqi.send_queue_count), 64'(model_count));
        checkOutput("empty", 64'(sqi.send_queue_empty), 64'(model_count == 0));
        checkOutput("ready", 64'(sqi.send_queue_decode_ready), 64'(model_count < DEPTH));
        checkOutput("valid", 64'(sqi.send_queue_postoffice_valid), 64'(model_count != 0));
        if (model_count != 0) begin
            checkOutput("head_data", 64'(sqi.send_queue_postoffice_data), 64'(sb[0]));
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (model_count != 0 && po_ready) begin
                void'(sb.pop_front());
            end
            if (valid && model_count < DEPTH) begin
                sb.push_back(req);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic po_ready);
        applyStimulus(1'b0, 5'd0, 32'd0, po_ready, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        sqi.decode_send_queue_valid     = 1'b0;
        sqi.decode_send_queue_data      = '0;
        sqi.postoffice_send_queue_ready = 1'b0;

        #3;
        checkOutput("rst_ready", 64'(sqi.send_queue_decode_ready), 64'd1);
        checkOutput("rst_valid", 64'(sqi.send_queue_postoffice_valid), 64'd0);
        checkOutput("rst_count", 64'(sqi.send_queue_count), 64'd0);
        checkOutput("rst_empty", 64'(sqi.send_queue_empty), 64'd1);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full with the postoffice stalled, offer a fifth request, then drain in order.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 5'(i), $urandom, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd5, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idleCycle(1'b1);
        idleCycle(1'b0);

        // Single push: invisible in its own cycle, popped immediately the next.
        applyStimulus(1'b1, 5'd7, $urandom, 1'b0, 1'b0);
        idleCycle(1'b1);
        idleCycle(1'b0);

        // Sustained push+pop at count 2, long enough to wrap the pointers twice.
        applyStimulus(1'b1, 5'd10, $urandom, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd11, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 5'(12 + i), $urandom, 1'b1, 1'b0);
        idleCycle(1'b1);
        idleCycle(1'b1);
        idleCycle(1'b0);

        // Full queue: push rejected in the popping cycle, accepted in the next.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'(22 + i), $urandom, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd26, 32'hCAFE_0001, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd26, 32'hCAFE_0001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idleCycle(1'b1);
        idleCycle(1'b0);

        // Flush at count 3 with simultaneous push and pop; only the later payload survives.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'(27 + i), $urandom, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd30, $urandom, 1'b1, 1'b1);
        applyStimulus(1'b1, 5'd31, 32'h1234_5678, 1'b0, 1'b0);
        idleCycle(1'b1);
        idleCycle(1'b0);

        // Asynchronous reset mid-stream at count 2.
        applyStimulus(1'b1, 5'd1, $urandom, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd2, $urandom, 1'b0, 1'b0);
        sqi.decode_send_queue_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ready", 64'(sqi.send_queue_decode_ready), 64'd1);
        checkOutput("async_rst_valid", 64'(sqi.send_queue_postoffice_valid), 64'd0);
        checkOutput("async_rst_count", 64'(sqi.send_queue_count), 64'd0);
        checkOutput("async_rst_empty", 64'(sqi.send_queue_empty), 64'd1);
        sb.delete();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 5'd3, $urandom, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd4, $urandom, 1'b1, 1'b0);
        idleCycle(1'b1);
        idleCycle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/send_queue.md
# send_queue

Parameterised in-order FIFO holding send requests between the decode/issue stage and the postoffice. It accepts requests whose destination register and outgoing message are already resolved, and holds them until the postoffice can accept them. It presents the oldest entry to the postoffice through a valid/ready handshake. It exposes occupancy so issue logic can stall or fence on outstanding sends, and it drops all contents on pipeline flush.

## Interface
Parameters:
- DEPTH, 4, number of entries; legal values ≥ 2, not required to be a power of two.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous pipeline flush; discards all entries.
- decode_send_queue_valid  input  1  upstream request present.
- send_queue_decode_ready  output  1  queue can accept a request this cycle.
- decode_send_queue_data  input  send_queue_data_t  request payload: .register and .message.
- send_queue_postoffice_valid  output  1  head entry valid.
- postoffice_send_queue_ready  input  1  postoffice consumes the head this cycle.
- send_queue_postoffice_data  output  send_queue_data_t  head entry payload.
- send_queue_count  output  CNT_W  number of valid entries.
- send_queue_empty  output  1  high when send_queue_count == 0.

## Operation
- Storage is a circular buffer of DEPTH entries with head (read) pointer, tail (write) pointer and count.
  - Each pointer advances by 1 and wraps from DEPTH-1 to 0.
  - Full is count == DEPTH; empty is count == 0.
- Push: push = decode_send_queue_valid & send_queue_decode_ready & !flush.
  - Writes mem[tail] and advances tail.
- Pop: pop = send_queue_postoffice_valid & postoffice_send_queue_ready & !flush.
  - Advances head.
- Ready: send_queue_decode_ready = !full.
  - Registered-state only; it does not depend on postoffice_send_queue_ready.
  - No push is possible while full, even when a pop occurs in the same cycle.
- Valid and data:
  - send_queue_postoffice_valid = !empty.
  - send_queue_postoffice_data = mem[head].
  - Data is don't-care while valid is low.
- Count update:
  - push only: count+1.
  - pop only: count−1.
  - push and pop together: count unchanged, both pointers advance.
  - Neither: count unchanged.
- Entries leave strictly in arrival order. Payload is never modified.
- Flush: on a cycle with flush high, the next state is head = tail = 0, count = 0.
  - Any push or pop in that cycle is discarded.
  - Memory contents need not be cleared.
- Reset forces the same state as flush, asynchronously.
  - Reset values: send_queue_decode_ready 1, send_queue_postoffice_valid 0, send_queue_count 0, send_queue_empty 1.
- While postoffice_send_queue_ready is low, a valid head stays valid with stable data (no retraction) until it is popped or flushed.

## Timing
- Push-to-visible latency is 1 cycle.
  - A push at edge N to an empty queue makes send_queue_postoffice_valid high after edge N. There is no same-cycle bypass.
- Pop takes effect at the clock edge. The next entry, if any, is presented in the following cycle with no bubble.
- Throughput is 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- Count, empty and ready all derive from registered state, with no combinational input-to-output paths. The exception is data, which is muxed from registered head and memory.
- Flush and reset mid-operation:
  - Valid drops low in the cycle after flush.
  - Ready returns high in the cycle after flush, even if the queue was full.

## Test plan
- Reset, then push 4 requests (register 1..4) on consecutive cycles with postoffice ready low (DEPTH=4):
  - Ready drops low after the 4th push; count=4.
  - A 5th valid request is not accepted.
  - Raising postoffice ready pops registers 1,2,3,4 in order over 4 cycles.
- Single push to an empty queue:
  - Valid is low in the push cycle and high the next cycle with matching payload.
  - Count goes 0→1→0 when popped immediately.
- Concurrent push and pop at count=2 held for 10 cycles:
  - Count stays 2.
  - Output sequence equals input sequence, crossing pointer wrap at least twice.
- Full queue with pop and valid push in the same cycle:
  - The push is rejected (ready low).
  - Count goes 4→3, and the push is accepted the following cycle.
- Flush at count=3 with a simultaneous push and pop:
  - Next cycle count=0, valid=0, ready=1, empty=1.
  - A subsequent push delivers only the new payload.
- Assert rst_n low asynchronously mid-stream at count=2:
  - Outputs take reset values immediately.
  - After release, normal push/pop resumes with count starting at 0.
